// File: rtl/layer_stream_ctrl_if.sv
// Stream bundle between a beat producer / result consumer and layer_stream_ctrl.
// The master drives input beats and the result ready; the slave is the controller.
interface layer_stream_ctrl_if #(
   parameter int unsigned BIT_WIDTH   = 32,
   parameter int unsigned EXTRA_BITS  = 2,
   parameter int unsigned NUM_NEURONS = 40,
   parameter int unsigned MAX_INPUTS  = 16
);
   localparam int unsigned W     = BIT_WIDTH + EXTRA_BITS;
   localparam int unsigned CNT_W = $clog2(MAX_INPUTS + 1);

   // Input beat channel
   logic                     in_valid;
   logic                     in_ready;
   logic [W-1:0]             in_scaler;
   logic [W*NUM_NEURONS-1:0] in_weights;
   logic                     in_last;
   logic [NUM_NEURONS-1:0]   neuron_mask;

   // Result channel
   logic                     out_valid;
   logic                     out_ready;
   logic [W*NUM_NEURONS-1:0] out_result;
   logic [CNT_W-1:0]         out_count;
   logic                     out_ovf;

   modport master (
      output in_valid, in_scaler, in_weights, in_last, neuron_mask, out_ready,
      input  in_ready, out_valid, out_result, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_scaler, in_weights, in_last, neuron_mask, out_ready,
      output in_ready, out_valid, out_result, out_count, out_ovf
   );
endinterface

// File: rtl/layer_stream_ctrl.sv
// Streaming front-end and sequencer for the LAYER accumulator array.
// Clears the layer at the start of each vector, feeds one beat per transfer with
// ACC_EN driven from the per-vector mask, waits out the MAC pipeline and then
// presents the masked ACC_RESULT on a valid/ready result port.
// Optional macro LAYER_CTRL_PERF_EN adds the 16-bit perf_stalls counter port.
module layer_stream_ctrl #(
   parameter int unsigned BIT_WIDTH   = 32,
   parameter int unsigned EXTRA_BITS  = 2,
   parameter int unsigned NUM_NEURONS = 40,
   parameter int unsigned MAX_INPUTS  = 16,
   parameter int unsigned MAC_LATENCY = 4
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   layer_stream_ctrl_if.slave                                strm,
   output logic [(BIT_WIDTH+EXTRA_BITS)*NUM_NEURONS-1:0]     layer_weight_vector,
   output logic [BIT_WIDTH+EXTRA_BITS-1:0]                   layer_input_scaler,
   output logic [NUM_NEURONS-1:0]                            layer_acc_en,
   output logic                                              layer_acc_clr,
   input  logic [(BIT_WIDTH+EXTRA_BITS)*NUM_NEURONS-1:0]     layer_acc_result
`ifdef LAYER_CTRL_PERF_EN
   ,
   output logic [15:0]                                       perf_stalls
`endif
);

   localparam int unsigned W     = BIT_WIDTH + EXTRA_BITS;
   localparam int unsigned CNT_W = $clog2(MAX_INPUTS + 1);
   localparam int unsigned DW    = $clog2(MAC_LATENCY + 1);

   localparam logic [CNT_W-1:0] CntMax     = CNT_W'(MAX_INPUTS);
   localparam logic [CNT_W-1:0] CntLastOne = CNT_W'(MAX_INPUTS - 1);
   localparam logic [DW-1:0]    DrainLoad  = DW'(MAC_LATENCY);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAccum,
      StDrain,
      StHold
   } state_e;

   state_e                   state_q;
   logic [NUM_NEURONS-1:0]   mask_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [DW-1:0]            drain_q;
   logic                     in_ready_q;
   logic [NUM_NEURONS-1:0]   acc_en_q;
   logic                     acc_clr_q;
   logic [W*NUM_NEURONS-1:0] weight_q;
   logic [W-1:0]             scaler_q;
   logic                     out_valid_q;
   logic [W*NUM_NEURONS-1:0] out_result_q;
   logic [CNT_W-1:0]         out_count_q;
   logic                     out_ovf_q;
`ifdef LAYER_CTRL_PERF_EN
   logic [15:0]              perf_q;
`endif

   logic                     xfer;
   logic                     hit_max;
   logic [W*NUM_NEURONS-1:0] masked_result;

   // in_ready_q is only ever high in StAccum, so this is the accepted-beat strobe
   assign xfer    = strm.in_valid & in_ready_q;
   // This transfer fills the last free slot of the vector
   assign hit_max = (cnt_q == CntLastOne);

   // Lanes disabled for this vector read back as zero regardless of the layer
   always_comb begin
      masked_result = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (mask_q[i]) begin
            masked_result[i*W +: W] = layer_acc_result[i*W +: W];
         end
      end
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         mask_q       <= '0;
         cnt_q        <= '0;
         drain_q      <= '0;
         in_ready_q   <= 1'b0;
         acc_en_q     <= '0;
         acc_clr_q    <= 1'b0;
         weight_q     <= '0;
         scaler_q     <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_count_q  <= '0;
         out_ovf_q    <= 1'b0;
`ifdef LAYER_CTRL_PERF_EN
         perf_q       <= '0;
`endif
      end else begin
         // Single-cycle strobes default low
         acc_en_q  <= '0;
         acc_clr_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Beat stays on the bus; only the mask is taken here
               if (strm.in_valid) begin
                  mask_q    <= strm.neuron_mask;
                  acc_clr_q <= 1'b1;
                  cnt_q     <= '0;
                  out_ovf_q <= 1'b0;
`ifdef LAYER_CTRL_PERF_EN
                  perf_q    <= '0;
`endif
                  state_q   <= StClear;
               end
            end
            StClear: begin
               in_ready_q <= 1'b1;
               state_q    <= StAccum;
            end
            StAccum: begin
`ifdef LAYER_CTRL_PERF_EN
               if (!strm.in_valid && perf_q != 16'hFFFF) begin
                  perf_q <= perf_q + 16'd1;
               end
`endif
               if (xfer) begin
                  weight_q <= strm.in_weights;
                  scaler_q <= strm.in_scaler;
                  acc_en_q <= mask_q;
                  if (cnt_q != CntMax) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
                  if (strm.in_last || hit_max) begin
                     out_ovf_q  <= ~strm.in_last & hit_max;
                     in_ready_q <= 1'b0;
                     drain_q    <= DrainLoad;
                     state_q    <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (drain_q <= DW'(1)) begin
                  out_result_q <= masked_result;
                  out_count_q  <= cnt_q;
                  out_valid_q  <= 1'b1;
                  state_q      <= StHold;
               end else begin
                  drain_q <= drain_q - DW'(1);
               end
            end
            StHold: begin
               if (strm.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
`ifdef LAYER_CTRL_PERF_EN
               else if (perf_q != 16'hFFFF) begin
                  perf_q <= perf_q + 16'd1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign strm.in_ready       = in_ready_q;
   assign strm.out_valid      = out_valid_q;
   assign strm.out_result     = out_result_q;
   assign strm.out_count      = out_count_q;
   assign strm.out_ovf        = out_ovf_q;
   assign layer_weight_vector = weight_q;
   assign layer_input_scaler  = scaler_q;
   assign layer_acc_en        = acc_en_q;
   assign layer_acc_clr       = acc_clr_q;
`ifdef LAYER_CTRL_PERF_EN
   assign perf_stalls         = perf_q;
`endif

endmodule
